multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 3-bit-opcode accumulator CPU. Sequences the
//  fetch, decode, memory-access and execute phases over a shared single-port
//  memory with a ready handshake. Drives the same datapath strobes as the
//  single-cycle decoder (rd_mem, wr_mem, ac_src, ld_ac, pc_src, alu_add,
//  alu_sub, ld_imm), plus PC/IR load strobes and the memory address select.
// PARAMETERS
//  OPC_W   3    opcode width (instr[15:13])
//  AC_W    13   accumulator width, for the JEZ zero test
//  CNT_W   16   instruction-counter width (SEQ_ICOUNT_EN only)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      begin or resume execution (level, sampled in IDLE/HALT)
//  opcode    in   OPC_W  opcode field of memory read data (valid with mem_ready)
//  ir_op     in   OPC_W  opcode held in the datapath IR
//  ac        in   AC_W   accumulator value
//  mem_ready in   1      memory completes the current rd_mem/wr_mem access
//  addr_sel  out  1      0 = PC drives the address, 1 = IR address field
//  rd_mem    out  1      memory read request, held until mem_ready
//  wr_mem    out  1      memory write request (data = AC), held until mem_ready
//  ir_ld     out  1      load IR from read data
//  pc_inc    out  1      PC <= PC + 1
//  pc_src    out  1      PC <= IR address (jump)
//  ac_src    out  1      AC input mux selects memory data
//  ld_ac     out  1      load AC
//  alu_add   out  1      ALU performs AC + mem
//  alu_sub   out  1      ALU performs AC - mem
//  ld_imm    out  1      AC <= sign-extended IR immediate
//  halted    out  1      high in HALT state
// BEHAVIOUR
//  - State is registered. Outputs are combinational from state, ir_op, ac and
//    mem_ready. Every strobe except a held request is a 1-cycle pulse.
//  - Reset (asynchronous, any state): state = IDLE. All outputs read 0. No
//    strobe may glitch high while rst_n = 0.
//  - Opcodes: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 JMP, 101 JEZ, 110 LDI,
//    111 HLT.
//  - IDLE: outputs 0. start = 1 -> FETCH.
//  - FETCH: addr_sel = 0, rd_mem = 1.
//    - On mem_ready: ir_ld = 1 and pc_inc = 1 in the same cycle -> DECODE.
//    - Otherwise stay in FETCH.
//  - DECODE: dispatch on ir_op. ac is sampled in this cycle.
//    - LDA/ADD/SUB -> MEMRD.
//    - STA -> MEMWR.
//    - JMP: pc_src = 1 -> FETCH.
//    - JEZ: pc_src = (ac == 0) -> FETCH.
//    - LDI: ld_imm = 1, ld_ac = 1 -> FETCH.
//    - HLT -> HALT.
//  - MEMRD: addr_sel = 1, rd_mem = 1 until mem_ready. On mem_ready, pulse the
//    following, then -> FETCH:
//    - LDA: ac_src + ld_ac
//    - ADD: alu_add + ld_ac
//    - SUB: alu_sub + ld_ac
//  - MEMWR: addr_sel = 1, wr_mem = 1 until mem_ready -> FETCH.
//  - HALT: halted = 1, no fetch. start = 1 -> FETCH, resuming at the current PC.
//  - Latency with zero-wait memory (mem_ready high in the first request cycle):
//    - JMP/JEZ/LDI/HLT: 2 cycles.
//    - LDA/STA/ADD/SUB: 3 cycles.
//    - Each wait cycle extends the current state by 1.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - start outside IDLE/HALT is ignored.
//  - rd_mem and wr_mem are never high together.
//  - At most one of ac_src/alu_add/alu_sub/ld_imm is high at a time.
//  - Reset mid-access: the request drops immediately. A late mem_ready after
//    reset is ignored (state is IDLE).
// CONFIGURATION
//  - SEQ_ICOUNT_EN defined: adds output icount [CNT_W-1:0].
//    - Increments by 1 on every transition DECODE/MEMRD/MEMWR -> FETCH, i.e.
//      per retired instruction. HLT is not counted.
//    - Saturates at all ones.
//    - Cleared to 0 by reset and on IDLE -> FETCH. Held on HALT -> FETCH.
//  - SEQ_ICOUNT_EN undefined: icount port and counter logic are absent.
//    Behaviour is otherwise identical.
// TESTING
//  - Reset: rst_n = 0 during MEMRD with rd_mem = 1 -> all outputs 0 the same
//    cycle; after release, state IDLE until start.
//  - Zero-wait LDI, then HLT: start = 1, mem_ready = 1 ->
//    - FETCH: ir_ld = 1, pc_inc = 1
//    - DECODE: ld_imm = 1, ld_ac = 1
//    - next FETCH: ir_ld = 1
//    - then halted = 1
//    - 4 cycles total
//  - ADD with 2 wait states: in MEMRD, mem_ready low for 2 cycles then high ->
//    rd_mem high and addr_sel = 1 for 3 cycles; alu_add + ld_ac pulse only in
//    the 3rd cycle.
//  - JEZ: ac = 0 -> pc_src = 1 in DECODE. ac = 13'h0001 -> pc_src = 0, and the
//    next state is FETCH in both cases.
//  - STA: wr_mem = 1, addr_sel = 1, rd_mem = 0 until mem_ready; then FETCH.
//    start pulsed mid-STA has no effect.
//  - SEQ_ICOUNT_EN:
//    - Program LDI, LDA, STA, HLT -> icount = 3 while halted.
//    - start from HALT -> icount still 3.
//    - With CNT_W = 2, run 5 instructions -> icount = 3 (saturated).

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/memory/execute control FSM for the accumulator CPU.
// Optional SEQ_ICOUNT_EN adds a saturating retired-instruction counter.
module multicycle_sequencer #(
  parameter int OPC_W = 3,
  parameter int AC_W  = 13,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OPC_W-1:0] ir_op,
  input  logic [AC_W-1:0]  ac,
  input  logic             mem_ready,
  output logic             addr_sel,
  output logic             rd_mem,
  output logic             wr_mem,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_src,
  output logic             ac_src,
  output logic             ld_ac,
  output logic             alu_add,
  output logic             alu_sub,
  output logic             ld_imm,
  output logic             halted
`ifdef SEQ_ICOUNT_EN
  ,
  output logic [CNT_W-1:0] icount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_MEMWR,
    S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   cnt_inc, cnt_clr;

  logic op_lda, op_sta, op_add, op_sub;
  logic op_jmp, op_jez, op_ldi, op_hlt;

  assign op_lda = ir_op == OPC_W'(0);
  assign op_sta = ir_op == OPC_W'(1);
  assign op_add = ir_op == OPC_W'(2);
  assign op_sub = ir_op == OPC_W'(3);
  assign op_jmp = ir_op == OPC_W'(4);
  assign op_jez = ir_op == OPC_W'(5);
  assign op_ldi = ir_op == OPC_W'(6);
  assign op_hlt = ir_op == OPC_W'(7);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and strobes
  always_comb begin
    state_d  = state_q;
    addr_sel = 1'b0;
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_src   = 1'b0;
    ac_src   = 1'b0;
    ld_ac    = 1'b0;
    alu_add  = 1'b0;
    alu_sub  = 1'b0;
    ld_imm   = 1'b0;
    halted   = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_clr = 1'b1;
        end
      end
      S_FETCH: begin
        rd_mem = 1'b1;
        if (mem_ready) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          op_lda, op_add, op_sub: state_d = S_MEMRD;
          op_sta: state_d = S_MEMWR;
          op_jmp: begin
            pc_src  = 1'b1;
            state_d = S_FETCH;
            cnt_inc = 1'b1;
          end
          op_jez: begin
            pc_src  = ac == '0;
            state_d = S_FETCH;
            cnt_inc = 1'b1;
          end
          op_ldi: begin
            ld_imm  = 1'b1;
            ld_ac   = 1'b1;
            state_d = S_FETCH;
            cnt_inc = 1'b1;
          end
          op_hlt: state_d = S_HALT;
          default: state_d = S_HALT;
        endcase
      end
      S_MEMRD: begin
        addr_sel = 1'b1;
        rd_mem   = 1'b1;
        if (mem_ready) begin
          ac_src  = op_lda;
          alu_add = op_add;
          alu_sub = op_sub;
          ld_ac   = 1'b1;
          state_d = S_FETCH;
          cnt_inc = 1'b1;
        end
      end
      S_MEMWR: begin
        addr_sel = 1'b1;
        wr_mem   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          cnt_inc = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Opcode arrives through the IR; the raw read-data field is not needed here
`ifdef SEQ_ICOUNT_EN
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             unused_sig;

  assign unused_sig = ^opcode;

  // Retired-instruction count, saturating, cleared on a fresh start
  always_comb begin
    icount_d = icount_q;
    if (cnt_clr)
      icount_d = '0;
    else if (cnt_inc && icount_q != '1)
      icount_d = icount_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) icount_q <= '0;
    else        icount_q <= icount_d;
  end

  assign icount = icount_q;
`else
  logic unused_sig;

  assign unused_sig = ^{opcode, cnt_inc, cnt_clr, CNT_W[0]};
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed vector table, reset corner case,
// then a randomized program checked against a per-instruction cycle model.
module tb_multicycle_sequencer;

  localparam int TCW = 4;
  localparam logic [11:0] AS = 12'h800, RD = 12'h400, WR = 12'h200;
  localparam logic [11:0] IRLD = 12'h100, PCI = 12'h080, PCS = 12'h040;
  localparam logic [11:0] ACS = 12'h020, LDAC = 12'h010, ADD = 12'h008;
  localparam logic [11:0] SUB = 12'h004, LDIM = 12'h002, HLTD = 12'h001;
  localparam logic [11:0] FET = RD | IRLD | PCI;
  localparam logic [2:0] LDA_ = 3'd0, STA_ = 3'd1, ADD_ = 3'd2, SUB_ = 3'd3;
  localparam logic [2:0] JMP_ = 3'd4, JEZ_ = 3'd5, LDI_ = 3'd6, HLT_ = 3'd7;

  logic clk = 1'b0;
  logic rst_n, start, mem_ready;
  logic [2:0] opcode, ir_op;
  logic [12:0] ac;
  logic addr_sel, rd_mem, wr_mem, ir_ld, pc_inc, pc_src;
  logic ac_src, ld_ac, alu_add, alu_sub, ld_imm, halted;
`ifdef SEQ_ICOUNT_EN
  logic [TCW-1:0] icount;
`endif

  int nvec = 0;
  int nfail = 0;
  logic [2:0] irop_cur;
  int unsigned cnt_m;

  always #5 clk = ~clk;

  multicycle_sequencer #(.OPC_W(3), .AC_W(13), .CNT_W(TCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .ir_op(ir_op), .ac(ac), .mem_ready(mem_ready),
    .addr_sel(addr_sel), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_src(pc_src),
    .ac_src(ac_src), .ld_ac(ld_ac), .alu_add(alu_add),
    .alu_sub(alu_sub), .ld_imm(ld_imm), .halted(halted)
`ifdef SEQ_ICOUNT_EN
    , .icount(icount)
`endif
  );

  logic [11:0] outv;
  assign outv = {addr_sel, rd_mem, wr_mem, ir_ld, pc_inc, pc_src,
                 ac_src, ld_ac, alu_add, alu_sub, ld_imm, halted};

  typedef struct {
    logic        s;
    logic        mr;
    logic [2:0]  op;
    logic [12:0] a;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic mr, logic [2:0] op,
                              logic [12:0] a, logic [11:0] exp);
    vec_t v;
    v.s = s; v.mr = mr; v.op = op; v.a = a; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input logic [11:0] exp, input string name);
    nvec++;
    if (outv !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h at %0t", name, outv, exp, $time);
    end
  endtask

  task automatic apply(input logic s, input logic mr, input logic [2:0] op,
                       input logic [2:0] irop, input logic [12:0] a,
                       input logic [11:0] exp, input string name);
    @(negedge clk);
    start = s; mem_ready = mr; opcode = op; ir_op = irop; ac = a;
    #1;
    chk(exp, name);
  endtask

  task automatic chk_cnt(input string name);
`ifdef SEQ_ICOUNT_EN
    nvec++;
    if (icount !== TCW'(cnt_m)) begin
      nfail++;
      $display("FAIL %s: icount got %0d want %0d", name, icount, cnt_m);
    end
`endif
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [12:0] rac();
    return ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom);
  endfunction

  task automatic retire();
    if (cnt_m < (1 << TCW) - 1) cnt_m++;
  endtask

  task automatic do_fetch(input logic [2:0] op);
    int w = $urandom_range(0, 2);
    repeat (w) apply(rb(), 1'b0, 3'($urandom), irop_cur, rac(), RD, "fetch_wait");
    apply(rb(), 1'b1, op, irop_cur, rac(), FET, "fetch");
    irop_cur = op;
  endtask

  task automatic do_exec(input logic [2:0] op);
    logic [12:0] a = rac();
    logic [11:0] e = 12'h000;
    logic [11:0] st = 12'h000;
    int w = $urandom_range(0, 2);
    int k = $urandom_range(0, 2);
    if (op == JMP_) e = PCS;
    if (op == JEZ_ && a == 13'd0) e = PCS;
    if (op == LDI_) e = LDIM | LDAC;
    apply(rb(), rb(), 3'($urandom), op, a, e, "decode");
    if (op == LDA_) st = ACS;
    if (op == ADD_) st = ADD;
    if (op == SUB_) st = SUB;
    if (op == LDA_ || op == ADD_ || op == SUB_) begin
      repeat (w) apply(rb(), 1'b0, 3'($urandom), op, rac(), AS | RD, "memrd_wait");
      apply(rb(), 1'b1, 3'($urandom), op, rac(), AS | RD | st | LDAC, "memrd");
      retire();
    end else if (op == STA_) begin
      repeat (w) apply(rb(), 1'b0, 3'($urandom), op, rac(), AS | WR, "memwr_wait");
      apply(rb(), 1'b1, 3'($urandom), op, rac(), AS | WR, "memwr");
      retire();
    end else if (op == HLT_) begin
      repeat (k) apply(1'b0, rb(), 3'($urandom), op, rac(), HLTD, "halt");
      chk_cnt("icount_halt");
      apply(1'b1, rb(), 3'($urandom), op, rac(), HLTD, "halt_resume");
      chk_cnt("icount_resume");
    end else begin
      retire();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
    opcode = 3'd0; ir_op = 3'd0; ac = 13'd0;
    #7;
    chk(12'h000, "reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back(mk(0, 0, LDA_, 13'd0, 12'h000));
    tbl.push_back(mk(1, 0, LDA_, 13'd0, 12'h000));
    tbl.push_back(mk(0, 1, LDI_, 13'd0, FET));
    tbl.push_back(mk(0, 0, LDI_, 13'd0, LDIM | LDAC));
    tbl.push_back(mk(0, 1, HLT_, 13'd0, FET));
    tbl.push_back(mk(0, 0, HLT_, 13'd0, 12'h000));
    tbl.push_back(mk(0, 1, HLT_, 13'd0, HLTD));
    tbl.push_back(mk(1, 0, HLT_, 13'd0, HLTD));
    tbl.push_back(mk(0, 0, ADD_, 13'd0, RD));
    tbl.push_back(mk(0, 1, ADD_, 13'd0, FET));
    tbl.push_back(mk(0, 0, ADD_, 13'd0, 12'h000));
    tbl.push_back(mk(0, 0, ADD_, 13'd0, AS | RD));
    tbl.push_back(mk(0, 0, ADD_, 13'd0, AS | RD));
    tbl.push_back(mk(0, 1, ADD_, 13'd0, AS | RD | ADD | LDAC));
    tbl.push_back(mk(0, 1, JEZ_, 13'd0, FET));
    tbl.push_back(mk(0, 0, JEZ_, 13'd0, PCS));
    tbl.push_back(mk(0, 1, JEZ_, 13'd1, FET));
    tbl.push_back(mk(0, 0, JEZ_, 13'd1, 12'h000));
    tbl.push_back(mk(0, 1, STA_, 13'd0, FET));
    tbl.push_back(mk(1, 0, STA_, 13'd0, 12'h000));
    tbl.push_back(mk(1, 0, STA_, 13'd0, AS | WR));
    tbl.push_back(mk(0, 1, STA_, 13'd0, AS | WR));
    tbl.push_back(mk(0, 1, LDA_, 13'd0, FET));
    tbl.push_back(mk(0, 1, LDA_, 13'd0, 12'h000));
    tbl.push_back(mk(0, 1, LDA_, 13'd0, AS | RD | ACS | LDAC));
    tbl.push_back(mk(0, 1, SUB_, 13'd0, FET));
    tbl.push_back(mk(0, 0, SUB_, 13'd0, 12'h000));
    tbl.push_back(mk(0, 1, SUB_, 13'd0, AS | RD | SUB | LDAC));
    tbl.push_back(mk(0, 1, JMP_, 13'd0, FET));
    tbl.push_back(mk(0, 0, JMP_, 13'd0, PCS));
    tbl.push_back(mk(0, 0, JMP_, 13'd0, RD));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].s, tbl[i].mr, tbl[i].op, tbl[i].op, tbl[i].a,
            tbl[i].exp, $sformatf("tbl%0d", i));

    apply(0, 1, LDA_, LDA_, 13'd0, FET, "rst_fetch");
    apply(0, 0, LDA_, LDA_, 13'd0, 12'h000, "rst_decode");
    apply(0, 0, LDA_, LDA_, 13'd0, AS | RD, "rst_memrd");
    #1 rst_n = 1'b0;
    #1 chk(12'h000, "rst_async_drop");
    mem_ready = 1'b1;
    @(posedge clk);
    #1 chk(12'h000, "rst_held_late_ready");
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 1, LDA_, LDA_, 13'd0, 12'h000, "post_rst_idle0");
    apply(0, 1, LDA_, LDA_, 13'd0, 12'h000, "post_rst_idle1");

    irop_cur = LDA_;
    apply(1, rb(), 3'd0, irop_cur, rac(), 12'h000, "idle_start");
    cnt_m = 0;
    begin
      logic [2:0] prog[4];
      prog[0] = LDI_; prog[1] = LDA_; prog[2] = STA_; prog[3] = HLT_;
      for (int i = 0; i < 4; i++) begin
        do_fetch(prog[i]);
        do_exec(prog[i]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) == 0) ? HLT_ : 3'($urandom_range(0, 6));
      do_fetch(op);
      do_exec(op);
    end
    chk_cnt("icount_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
